exc_ctrl: RTL and testbench

- Pipeline-side initiator of the CP0 exception/return interface.
- Collects exception flags carried to the MEM (commit) stage, samples the CP0 interrupt request, and prioritises.
- Drives the CP0 exception pulse with ExcCode/EPC/BD/BadVaddr, or the ERET return pulse.
- Kills the committing instruction, flushes the younger pipeline stages, and redirects the PC to the exception vector or the CP0 return address.

---
 rtl/exc_pkg.sv | 35 +++
 rtl/exc_prio_enc.sv | 52 +++++
 rtl/exc_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_exc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// ----------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the MEM-stage exception controller:
//   - MIPS ExcCode values driven to CP0
//   - bit positions inside the mem_exc flag vector
//   - controller FSM state encoding
// ----------------------------------------------------------------------------
package exc_pkg;

  // ExcCode values written to CP0 CAUSE.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // mem_exc flag positions
  localparam int MEM_EXC_W        = 7;
  localparam int EXC_BIT_ADEL_IF  = 0;
  localparam int EXC_BIT_RI       = 1;
  localparam int EXC_BIT_OV       = 2;
  localparam int EXC_BIT_SYS      = 3;
  localparam int EXC_BIT_BP       = 4;
  localparam int EXC_BIT_ADEL_D   = 5;
  localparam int EXC_BIT_ADES     = 6;

  // Controller state: IDLE evaluates commits, FLUSH drains wrong-path work
  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// ----------------------------------------------------------------------------
// exc_prio_enc
// Combinational priority encoder for the committing instruction's causes.
// Order, highest first: Int, AdEL-fetch, RI, Ov, Sys, Bp, AdEL-data, AdES.
// Ports:
//   int_take    in   interrupt accepted this cycle (already commit-gated)
//   mem_exc     in   per-cause flags of the MEM instruction
//   mem_pc      in   PC of the MEM instruction (BadVAddr for fetch faults)
//   mem_ls_addr in   load/store address (BadVAddr for data faults)
//   code        out  ExcCode of the winning cause
//   badvaddr    out  faulting address, 0 for causes without one
//   any         out  at least one cause present
// ----------------------------------------------------------------------------
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic                 int_take,
  input  logic [MEM_EXC_W-1:0] mem_exc,
  input  logic [31:0]          mem_pc,
  input  logic [31:0]          mem_ls_addr,
  output logic [4:0]           code,
  output logic [31:0]          badvaddr,
  output logic                 any
);

  always_comb begin
    code     = EXC_INT;
    badvaddr = '0;
    any      = int_take | (|mem_exc);
    if (int_take) begin
      code = EXC_INT;
    end else if (mem_exc[EXC_BIT_ADEL_IF]) begin
      code     = EXC_ADEL;
      badvaddr = mem_pc;
    end else if (mem_exc[EXC_BIT_RI]) begin
      code = EXC_RI;
    end else if (mem_exc[EXC_BIT_OV]) begin
      code = EXC_OV;
    end else if (mem_exc[EXC_BIT_SYS]) begin
      code = EXC_SYS;
    end else if (mem_exc[EXC_BIT_BP]) begin
      code = EXC_BP;
    end else if (mem_exc[EXC_BIT_ADEL_D]) begin
      code     = EXC_ADEL;
      badvaddr = mem_ls_addr;
    end else if (mem_exc[EXC_BIT_ADES]) begin
      code     = EXC_ADES;
      badvaddr = mem_ls_addr;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// exc_ctrl
// MEM-stage initiator of the CP0 exception / ERET interface. Prioritises the
// committing instruction's exception flags against the CP0 interrupt request,
// pulses CP0, kills the committing instruction, flushes IF/ID/EX and
// redirects the PC.
//
// Optional build macro: EXC_STATS_EN
//   defined   -> exc_count counts exception pulses (saturating)
//   undefined -> exc_count is tied to 0
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   mem_valid/mem_stall       MEM holds a real instruction / is stalled
//   mem_pc/mem_bd             PC and delay-slot flag of the MEM instruction
//   mem_exc/mem_ls_addr       exception flags and load/store address
//   mem_eret                  MEM instruction is ERET
//   cp0_interrupt/cp0_exl     pending interrupt and STATUS.EXL
//   cp0_return_addr           EPC used as ERET target
//   mem_kill                  combinational: suppress MEM/WB side effects
//   exception/eret            registered 1-cycle pulses to CP0
//   exc_code/epc/bd/badvaddr  exception payload, valid with exception
//   flush                     flush IF/ID/EX
//   redirect_valid/pc         1-cycle PC load and its target
//   exc_count                 taken-exception counter
//   state_dbg                 current controller state
//
// Handshake: there is no back-pressure. A commit happens in any cycle where
// mem_valid=1, mem_stall=0 and the controller is IDLE; the resulting pulses
// appear exactly one cycle later and each lasts exactly one cycle.
// ----------------------------------------------------------------------------
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mem_valid,
  input  logic                 mem_stall,
  input  logic [31:0]          mem_pc,
  input  logic                 mem_bd,
  input  logic [MEM_EXC_W-1:0] mem_exc,
  input  logic [31:0]          mem_ls_addr,
  input  logic                 mem_eret,
  input  logic                 cp0_interrupt,
  input  logic                 cp0_exl,
  input  logic [31:0]          cp0_return_addr,
  output logic                 mem_kill,
  output logic                 exception,
  output logic                 eret,
  output logic [4:0]           exc_code,
  output logic [31:0]          exc_epc,
  output logic                 exc_bd,
  output logic [31:0]          exc_badvaddr,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [31:0]          exc_count,
  output exc_state_e           state_dbg
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  exc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        exception_q, exception_d;
  logic        eret_q, eret_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_epc_q, exc_epc_d;
  logic        exc_bd_q, exc_bd_d;
  logic [31:0] exc_badvaddr_q, exc_badvaddr_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        commit, int_take, exc_take, ret_take;
  logic [4:0]  enc_code;
  logic [31:0] enc_badvaddr;
  logic        enc_any;

  // MEM contents are only trusted while IDLE; in FLUSH they are wrong-path.
  always_comb begin
    commit   = mem_valid & ~mem_stall & (state_q == IDLE);
    int_take = commit & cp0_interrupt & ~cp0_exl;
  end

  exc_prio_enc u_prio (
    .int_take    (int_take),
    .mem_exc     (mem_exc),
    .mem_pc      (mem_pc),
    .mem_ls_addr (mem_ls_addr),
    .code        (enc_code),
    .badvaddr    (enc_badvaddr),
    .any         (enc_any)
  );

  always_comb begin
    exc_take = commit & enc_any;
    // An exception on the same instruction pre-empts the ERET.
    ret_take = commit & mem_eret & ~exc_take;
    mem_kill = exc_take;
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    flush_d          = flush_q;
    exception_d      = exc_take;
    eret_d           = ret_take;
    redirect_valid_d = exc_take | ret_take;
    redirect_pc_d    = '0;
    exc_code_d       = '0;
    exc_epc_d        = '0;
    exc_bd_d         = 1'b0;
    exc_badvaddr_d   = '0;

    if (exc_take) begin
      exc_code_d     = enc_code;
      exc_epc_d      = mem_bd ? (mem_pc - 32'd4) : mem_pc;
      exc_bd_d       = mem_bd;
      exc_badvaddr_d = enc_badvaddr;
      redirect_pc_d  = EXC_VECTOR;
    end else if (ret_take) begin
      redirect_pc_d  = cp0_return_addr;
    end

    case (state_q)
      IDLE: begin
        if (exc_take | ret_take) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        // Leave FLUSH on the edge where the counter hits zero, so flush is
        // high for exactly FLUSH_CYCLES cycles.
        if (cnt_q <= 3'd1) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          flush_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      cnt_q            <= 3'd0;
      exception_q      <= 1'b0;
      eret_q           <= 1'b0;
      exc_code_q       <= '0;
      exc_epc_q        <= '0;
      exc_bd_q         <= 1'b0;
      exc_badvaddr_q   <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      exception_q      <= exception_d;
      eret_q           <= eret_d;
      exc_code_q       <= exc_code_d;
      exc_epc_q        <= exc_epc_d;
      exc_bd_q         <= exc_bd_d;
      exc_badvaddr_q   <= exc_badvaddr_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign exception      = exception_q;
  assign eret           = eret_q;
  assign exc_code       = exc_code_q;
  assign exc_epc        = exc_epc_q;
  assign exc_bd         = exc_bd_q;
  assign exc_badvaddr   = exc_badvaddr_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign state_dbg      = state_q;

`ifdef EXC_STATS_EN
  logic [31:0] exc_count_q, exc_count_d;

  // Counted on the take, so the new value is visible alongside the pulse.
  always_comb begin
    exc_count_d = exc_count_q;
    if (exc_take && (exc_count_q != 32'hFFFF_FFFF)) begin
      exc_count_d = exc_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exc_count_q <= '0;
    end else begin
      exc_count_q <= exc_count_d;
    end
  end

  assign exc_count = exc_count_q;
`else
  assign exc_count = '0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exc_ctrl
// Scoreboard bench for exc_ctrl: the driver computes the expected CP0 event
// for each committed instruction and queues it; a negedge monitor pops and
// compares whenever the DUT presents a pulse, and checks mem_kill and flush
// every cycle against the reference model.
// ----------------------------------------------------------------------------
module tb_exc_ctrl;
  import exc_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          FC  = 2;
  localparam int          MAXC = 8192;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        mem_valid, mem_stall, mem_bd, mem_eret;
  logic [31:0] mem_pc, mem_ls_addr, cp0_return_addr;
  logic [6:0]  mem_exc;
  logic        cp0_interrupt, cp0_exl;
  logic        mem_kill, exception, eret, exc_bd, flush, redirect_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr, redirect_pc, exc_count;
  exc_state_e  state_dbg;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .mem_valid       (mem_valid),
    .mem_stall       (mem_stall),
    .mem_pc          (mem_pc),
    .mem_bd          (mem_bd),
    .mem_exc         (mem_exc),
    .mem_ls_addr     (mem_ls_addr),
    .mem_eret        (mem_eret),
    .cp0_interrupt   (cp0_interrupt),
    .cp0_exl         (cp0_exl),
    .cp0_return_addr (cp0_return_addr),
    .mem_kill        (mem_kill),
    .exception       (exception),
    .eret            (eret),
    .exc_code        (exc_code),
    .exc_epc         (exc_epc),
    .exc_bd          (exc_bd),
    .exc_badvaddr    (exc_badvaddr),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .exc_count       (exc_count),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          cyc;
    bit          is_exc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] bva;
    logic [31:0] rpc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  bit          exp_flush [MAXC];
  bit          exp_kill;
  int          busy_until;
  logic [31:0] exp_cnt;
  bit          mon_en;
  int          n_cmp, n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Reference cause selection straight from the priority table.
  function automatic void ref_cause(input bit ip, input logic [6:0] ex,
                                    input logic [31:0] pc, input logic [31:0] ls,
                                    output logic [4:0] code, output logic [31:0] bva);
    logic [4:0] codes [7];
    bit found;
    codes = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    code  = 5'd0;
    bva   = 32'd0;
    found = 0;
    if (!ip) begin
      for (int i = 0; i < 7; i++) begin
        if (!found && ex[i]) begin
          found = 1;
          code  = codes[i];
          if (i == 0)      bva = pc;
          else if (i >= 5) bva = ls;
          else             bva = 32'd0;
        end
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input bit st, input logic [31:0] pc, input bit bd,
                       input logic [6:0] ex, input logic [31:0] ls, input bit er,
                       input bit it, input bit xl, input logic [31:0] ra);
    exp_t e;
    int   now;
    bit   ip;
    @(posedge clk);
    #1;
    mem_valid = v; mem_stall = st; mem_pc = pc; mem_bd = bd; mem_exc = ex;
    mem_ls_addr = ls; mem_eret = er; cp0_interrupt = it; cp0_exl = xl;
    cp0_return_addr = ra;
    now      = cyc;
    exp_kill = 0;
    ip       = it && !xl;
    if (v && !st && now >= busy_until && (ip || ex != 7'd0 || er)) begin
      e.cyc = now + 1;
      e.bd  = 1'b0; e.epc = '0; e.bva = '0; e.code = '0;
      if (ip || ex != 7'd0) begin
        e.is_exc = 1;
        ref_cause(ip, ex, pc, ls, e.code, e.bva);
        e.epc    = bd ? pc - 32'd4 : pc;
        e.bd     = bd;
        e.rpc    = VEC;
        if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        exp_kill = 1;
      end else begin
        e.is_exc = 0;
        e.rpc    = ra;
      end
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      for (int k = 1; k <= FC; k++) if (now + k < MAXC) exp_flush[now + k] = 1;
      busy_until = now + FC + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'd0, 0, 7'd0, 32'd0, 0, 0, 0, 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("mem_kill", {31'd0, mem_kill}, {31'd0, exp_kill});
      check("flush", {31'd0, flush}, {31'd0, (cyc < MAXC) ? exp_flush[cyc] : 1'b0});
      check("exc_eret_exclusive", {31'd0, exception & eret}, 32'd0);
      if (exception || eret || redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pulse @cycle %0d: got exc=%0b eret=%0b redir=%0b, required none",
                   cyc, exception, eret, redirect_valid);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("exception", {31'd0, exception}, {31'd0, e.is_exc});
          check("eret", {31'd0, eret}, {31'd0, !e.is_exc});
          check("redirect_valid", {31'd0, redirect_valid}, 32'd1);
          check("redirect_pc", redirect_pc, e.rpc);
          if (e.is_exc) begin
            check("exc_code", {27'd0, exc_code}, {27'd0, e.code});
            check("exc_epc", exc_epc, e.epc);
            check("exc_bd", {31'd0, exc_bd}, {31'd0, e.bd});
            check("exc_badvaddr", exc_badvaddr, e.bva);
          end
`ifdef EXC_STATS_EN
          check("exc_count", exc_count, e.cnt);
`else
          check("exc_count", exc_count, 32'd0);
`endif
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_pulse @cycle %0d: got no pulse, required one at cycle %0d", cyc, e.cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] ex;
    int sel;
    n_cmp = 0; n_err = 0; mon_en = 0; exp_kill = 0; busy_until = 0; exp_cnt = 0;
    rstn = 1'b0;
    mem_valid = 0; mem_stall = 0; mem_pc = 0; mem_bd = 0; mem_exc = 0;
    mem_ls_addr = 0; mem_eret = 0; cp0_interrupt = 0; cp0_exl = 0; cp0_return_addr = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_exception", {31'd0, exception}, 32'd0);
    check("rst_eret", {31'd0, eret}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_exc_code", {27'd0, exc_code}, 32'd0);
    check("rst_exc_epc", exc_epc, 32'd0);
    check("rst_exc_count", exc_count, 32'd0);
    check("rst_state", {31'd0, state_dbg}, {31'd0, IDLE});
    rstn = 1'b1;
    mon_en = 1;
    idle(2);

    // Overflow
    drive(1, 0, 32'h0040_0010, 0, 7'b0000100, 32'd0, 0, 0, 0, 32'd0); idle(3);
    // Delay-slot AdES
    drive(1, 0, 32'h0040_0024, 1, 7'b1000000, 32'h1000_0003, 0, 0, 0, 32'd0); idle(3);
    // Interrupt over Sys, then masked by EXL
    drive(1, 0, 32'h0040_0030, 0, 7'b0001000, 32'd0, 0, 1, 0, 32'd0); idle(3);
    drive(1, 0, 32'h0040_0030, 0, 7'b0001000, 32'd0, 0, 1, 1, 32'd0); idle(3);
    // ERET, then ERET plus RI
    drive(1, 0, 32'h0040_0040, 0, 7'b0000000, 32'd0, 1, 0, 0, 32'h0040_0100); idle(3);
    drive(1, 0, 32'h0040_0040, 0, 7'b0000010, 32'd0, 1, 0, 0, 32'h0040_0100); idle(3);
    // AdEL-fetch and AdEL-data together: fetch wins, BadVAddr is the PC
    drive(1, 0, 32'h0040_0051, 0, 7'b0100001, 32'h2000_0001, 0, 0, 0, 32'd0); idle(3);
    // Stall with RI, then a flagged instruction, then another during FLUSH
    drive(1, 1, 32'h0040_0060, 0, 7'b0000010, 32'd0, 0, 0, 0, 32'd0);
    drive(1, 0, 32'h0040_0064, 0, 7'b0010000, 32'd0, 0, 0, 0, 32'd0);
    drive(1, 0, 32'h0040_0068, 0, 7'b0000010, 32'd0, 0, 0, 0, 32'd0);
    drive(1, 0, 32'h0040_006C, 0, 7'b0000100, 32'd0, 1, 1, 0, 32'd0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      ex = 7'd0;
      else if (sel < 8) ex = 7'(1 << $urandom_range(0, 6));
      else              ex = 7'($urandom_range(0, 127));
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 1) == 1, ex,
            32'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) == 1, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end
    idle(5);
    check("queue_drained", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a flush window
    drive(1, 0, 32'h0040_0200, 0, 7'b0000100, 32'd0, 0, 0, 0, 32'd0);
    @(posedge clk);
    #2;
    mon_en = 0;
    rstn   = 1'b0;
    #1;
    check("midflush_rst_flush", {31'd0, flush}, 32'd0);
    check("midflush_rst_exception", {31'd0, exception}, 32'd0);
    check("midflush_rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("midflush_rst_state", {31'd0, state_dbg}, {31'd0, IDLE});
    check("midflush_rst_count", exc_count, 32'd0);
    mem_valid = 0; mem_exc = 0;
    exp_q.delete();
    for (int k = 0; k < MAXC; k++) exp_flush[k] = 0;
    exp_kill = 0; busy_until = 0; exp_cnt = 0;
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    mon_en = 1;

    // Three exceptions after reset
    drive(1, 0, 32'h0040_0300, 0, 7'b0001000, 32'd0, 0, 0, 0, 32'd0); idle(3);
    drive(1, 0, 32'h0040_0304, 0, 7'b0010000, 32'd0, 0, 0, 0, 32'd0); idle(3);
    drive(1, 0, 32'h0040_0308, 1, 7'b0000010, 32'd0, 0, 0, 0, 32'd0); idle(3);
`ifdef EXC_STATS_EN
    check("final_exc_count", exc_count, 32'd3);
`else
    check("final_exc_count", exc_count, 32'd0);
`endif
    check("final_queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
